// File: rtl/handshake_constant_buffered.sv
// rtl/handshake_constant_buffered.sv - buffered constant source: pending ctrl-token count, REPEAT tokens of VALUE each
module handshake_constant_buffered #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] VALUE      = {DATA_WIDTH{1'b1}},
  parameter int                    DEPTH      = 2,
  parameter int                    REPEAT     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_valid,
  output logic                         ctrl_ready,
  output logic [DATA_WIDTH-1:0]        outs,
  output logic                         outs_valid,
  input  logic                         outs_ready,
  output logic                         outs_last,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [PW-1:0] PEND_FULL = PW'(DEPTH);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT - 1);

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "handshake_constant_buffered: DEPTH must be >= 1");
  end
  if (REPEAT < 1) begin : g_bad_repeat
    $fatal(1, "handshake_constant_buffered: REPEAT must be >= 1");
  end

  logic [PW-1:0] pend_q, pend_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          acc, emt, fin;

  // Every output is a decode of pend_q/rep_q, so no input reaches an output combinationally.
  assign ctrl_ready = (pend_q != PEND_FULL);
  assign outs_valid = (pend_q != '0);
  assign outs_last  = outs_valid && (rep_q == REP_LAST);
  assign occupancy  = pend_q;
  assign outs       = VALUE;

  assign acc = ctrl_valid && ctrl_ready;
  assign emt = outs_valid && outs_ready;
  assign fin = emt && (rep_q == REP_LAST);

  always_comb begin
    rep_d = rep_q;
    if (fin) begin
      rep_d = '0;
    end else if (emt) begin
      rep_d = rep_q + RW'(1);
    end

    pend_d = pend_q;
    if (acc && !fin) begin
      pend_d = pend_q + PW'(1);
    end else if (!acc && fin) begin
      pend_d = pend_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      rep_q  <= '0;
    end else begin
      pend_q <= pend_d;
      rep_q  <= rep_d;
    end
  end

endmodule

// File: tb/tb_handshake_constant_buffered.sv
// tb/tb_handshake_constant_buffered.sv - directed and randomized checks of handshake_constant_buffered
module tb_handshake_constant_buffered;

  localparam int NCFG        = 6;
  localparam int RAND_CYCLES = 10000;

  function automatic int dep_of(input int g);
    return (g < 2) ? 1 : ((g < 4) ? 2 : 4);
  endfunction

  function automatic int rep_of(input int g);
    return (g % 2 == 1) ? 4 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        a_cv = 1'b0, a_or = 1'b0;
  logic        a_cr, a_ov, a_ol;
  logic [31:0] a_outs;
  logic [1:0]  a_occ;

  handshake_constant_buffered u_a (
    .clk(clk), .rst(rst), .ctrl_valid(a_cv), .ctrl_ready(a_cr), .outs(a_outs),
    .outs_valid(a_ov), .outs_ready(a_or), .outs_last(a_ol), .occupancy(a_occ)
  );

  logic       b_cv = 1'b0, b_or = 1'b0;
  logic       b_cr, b_ov, b_ol;
  logic [7:0] b_outs;
  logic [1:0] b_occ;

  handshake_constant_buffered #(.DATA_WIDTH(8), .VALUE(8'h5A), .DEPTH(2), .REPEAT(3)) u_b (
    .clk(clk), .rst(rst), .ctrl_valid(b_cv), .ctrl_ready(b_cr), .outs(b_outs),
    .outs_valid(b_ov), .outs_ready(b_or), .outs_last(b_ol), .occupancy(b_occ)
  );

  logic        r_cv [NCFG];
  logic        r_or [NCFG];
  wire         r_cr [NCFG];
  wire         r_ov [NCFG];
  wire         r_ol [NCFG];
  wire  [31:0] r_outs [NCFG];
  wire  [2:0]  r_occ [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_rand
    localparam int D = dep_of(g);
    localparam int R = rep_of(g);
    logic [$clog2(D+1)-1:0] occ_w;
    handshake_constant_buffered #(.DATA_WIDTH(32), .DEPTH(D), .REPEAT(R)) u_r (
      .clk(clk), .rst(rst), .ctrl_valid(r_cv[g]), .ctrl_ready(r_cr[g]), .outs(r_outs[g]),
      .outs_valid(r_ov[g]), .outs_ready(r_or[g]), .outs_last(r_ol[g]), .occupancy(occ_w)
    );
    assign r_occ[g] = 3'(occ_w);
  end

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({a_cr, a_ov, a_ol, a_occ} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_a got=%b exp=10000", {a_cr, a_ov, a_ol, a_occ});
    end
    n_cmp++;
    if ({b_cr, b_ov, b_ol, b_occ} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_b got=%b exp=10000", {b_cr, b_ov, b_ol, b_occ});
    end
    n_cmp++;
    if (a_outs !== 32'hFFFF_FFFF || b_outs !== 8'h5A) begin
      n_bad++; $display("FAIL reset_outs got=%h/%h exp=ffffffff/5a", a_outs, b_outs);
    end
    @(negedge clk);
    rst  = 1'b1;
    a_cv = 1'b1;
    a_or = 1'b0;
    repeat (3) @(negedge clk);
    a_cv = 1'b0;
    n_cmp++;
    if ({a_cr, a_ov, a_occ} !== 4'b0110) begin
      n_bad++; $display("FAIL fill_before_reset got=%b exp=0110", {a_cr, a_ov, a_occ});
    end
    // Reset lands between clock edges: outputs must clear without a clock.
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({a_cr, a_ov, a_ol, a_occ} !== 5'b10000 || a_outs !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL async_reset got=%b outs=%h exp=10000 outs=ffffffff",
                        {a_cr, a_ov, a_ol, a_occ}, a_outs);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_cr, a_ov, a_occ} !== 4'b1000) begin
      n_bad++; $display("FAIL after_release got=%b exp=1000", {a_cr, a_ov, a_occ});
    end
  endtask

  task automatic test_streaming();
    int acc_n = 0;
    int emt_n = 0;
    @(negedge clk);
    a_cv = 1'b1;
    a_or = 1'b1;
    n_cmp++;
    if (a_ov !== 1'b0) begin
      n_bad++; $display("FAIL stream_pre_valid got=%b exp=0", a_ov);
    end
    if (a_cv && a_cr) acc_n++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_cr, a_ov, a_ol, a_occ} !== 5'b11101) begin
        n_bad++; $display("FAIL stream_cycle%0d got=%b exp=11101", i, {a_cr, a_ov, a_ol, a_occ});
      end
      if (a_ov && a_or) emt_n++;
      if (i == 9) a_cv = 1'b0;
      if (a_cv && a_cr) acc_n++;
    end
    @(negedge clk);
    a_or = 1'b0;
    n_cmp++;
    if (acc_n != 10 || emt_n != 10) begin
      n_bad++; $display("FAIL stream_counts got=%0d/%0d exp=10/10", acc_n, emt_n);
    end
    n_cmp++;
    if ({a_ov, a_occ} !== 3'b000) begin
      n_bad++; $display("FAIL stream_drain got=%b exp=000", {a_ov, a_occ});
    end
  endtask

  task automatic test_backpressure();
    int acc_n = 0;
    int emt_n = 0;
    a_or = 1'b0;
    a_cv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (a_cv && a_cr) acc_n++;
      @(negedge clk);
    end
    a_cv = 1'b0;
    n_cmp++;
    if (acc_n != 2) begin
      n_bad++; $display("FAIL bp_accepted got=%0d exp=2", acc_n);
    end
    n_cmp++;
    if ({a_cr, a_ov, a_occ} !== 4'b0110) begin
      n_bad++; $display("FAIL bp_full got=%b exp=0110", {a_cr, a_ov, a_occ});
    end
    a_or = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (a_ov && a_or) emt_n++;
      @(negedge clk);
    end
    a_or = 1'b0;
    n_cmp++;
    if (emt_n != 2 || a_occ !== 2'd0) begin
      n_bad++; $display("FAIL bp_release got=%0d occ=%0d exp=2 occ=0", emt_n, a_occ);
    end
  endtask

  task automatic test_repeat();
    b_or = 1'b1;
    b_cv = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({b_ov, b_ol, b_occ} !== 4'b0000) begin
      n_bad++; $display("FAIL rep_idle got=%b exp=0000", {b_ov, b_ol, b_occ});
    end
    b_cv = 1'b1;
    @(negedge clk);
    b_cv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({b_ov, b_ol, b_occ, b_outs} !== {1'b1, (k == 2), 2'd1, 8'h5A}) begin
        n_bad++; $display("FAIL rep_token%0d got=%h exp=%h", k, {b_ov, b_ol, b_occ, b_outs},
                          {1'b1, (k == 2), 2'd1, 8'h5A});
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({b_ov, b_ol, b_occ} !== 4'b0000) begin
      n_bad++; $display("FAIL rep_done got=%b exp=0000", {b_ov, b_ol, b_occ});
    end
  endtask

  task automatic test_repeat_stall();
    int pat [5] = '{1, 0, 1, 0, 1};
    int em = 0;
    b_or = 1'b0;
    b_cv = 1'b1;
    @(negedge clk);
    b_cv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_or = (pat[i] != 0);
      n_cmp++;
      if ({b_ov, b_ol, b_occ} !== {1'b1, (em == 2), 2'd1}) begin
        n_bad++; $display("FAIL stall_cycle%0d got=%b exp=%b", i, {b_ov, b_ol, b_occ},
                          {1'b1, (em == 2), 2'd1});
      end
      if (pat[i] != 0) em++;
      @(negedge clk);
    end
    b_or = 1'b0;
    n_cmp++;
    if ({b_ov, b_occ} !== 3'b000) begin
      n_bad++; $display("FAIL stall_done got=%b exp=000", {b_ov, b_occ});
    end
  endtask

  // Model tracks only the number of output tokens still owed.
  task automatic test_random();
    int owed [NCFG];
    int acc_m [NCFG];
    int acc_d [NCFG];
    int emt_d [NCFG];
    logic [37:0] got_v, exp_v;
    int pc, po;
    for (int g = 0; g < NCFG; g++) begin
      owed[g] = 0; acc_m[g] = 0; acc_d[g] = 0; emt_d[g] = 0;
    end
    for (int c = 0; c < RAND_CYCLES; c++) begin
      pc = (c < 3000) ? 85 : ((c < 6000) ? 25 : 55);
      po = (c < 3000) ? 30 : ((c < 6000) ? 85 : 55);
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
        int d, r, pm;
        logic rdy_m, val_m, last_m;
        d = dep_of(g);
        r = rep_of(g);
        pm = (owed[g] + r - 1) / r;
        rdy_m = (pm < d);
        val_m = (owed[g] > 0);
        last_m = val_m && (((owed[g] - 1) % r) == 0);
        exp_v = {rdy_m, val_m, last_m, 3'(pm), 32'hFFFF_FFFF};
        got_v = {r_cr[g], r_ov[g], r_ol[g], r_occ[g], r_outs[g]};
        n_cmp++;
        if (got_v !== exp_v) begin
          n_bad++; $display("FAIL rand_cfg%0d_cycle%0d got=%h exp=%h", g, c, got_v, exp_v);
        end
        n_cmp++;
        if (r_cr[g] && (r_occ[g] == 3'(d))) begin
          n_bad++; $display("FAIL rand_full_ready_cfg%0d cycle%0d got=1 exp=0", g, c);
        end
        r_cv[g] = ($urandom_range(99) < pc);
        r_or[g] = ($urandom_range(99) < po);
        if (r_cv[g] && r_cr[g]) acc_d[g]++;
        if (r_ov[g] && r_or[g]) emt_d[g]++;
        if (r_cv[g] && rdy_m) begin
          owed[g] += r;
          acc_m[g]++;
        end
        if (val_m && r_or[g]) owed[g] -= 1;
      end
    end
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      r_cv[g] = 1'b0;
      r_or[g] = 1'b0;
      n_cmp++;
      if (acc_d[g] != acc_m[g] || emt_d[g] != rep_of(g) * acc_m[g] - owed[g]) begin
        n_bad++; $display("FAIL rand_scoreboard_cfg%0d got=%0d/%0d exp=%0d/%0d", g, acc_d[g],
                          emt_d[g], acc_m[g], rep_of(g) * acc_m[g] - owed[g]);
      end
    end
  endtask

  initial begin
    for (int g = 0; g < NCFG; g++) begin
      r_cv[g] = 1'b0;
      r_or[g] = 1'b0;
    end
    test_reset();
    test_streaming();
    test_backpressure();
    test_repeat();
    test_repeat_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
